// File: rtl/dfi_ctrl_arbiter.sv
// Memory-controller-side sequencer for the DFI update, PHY-master and low-power handshakes.
// Only one side-band transaction is granted at a time; forbidden DFI combinations cannot occur.
module dfi_ctrl_arbiter #(
  parameter int TLP_RESP     = 8,
  parameter int TPHYUPD_RESP = 16,
  parameter int TCTRLUPD_MIN = 2,
  parameter int TCTRLUPD_MAX = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       init_start,
  input  logic       mc_idle,
  input  logic       mc_ctrlupd_req,
  output logic       mc_ctrlupd_done,
  input  logic       mc_lp_req,
  input  logic [5:0] mc_lp_wakeup,
  output logic       mc_lp_active,
  output logic       mc_lp_timeout,
  output logic       dfi_ctrlupd_req,
  input  logic       dfi_ctrlupd_ack,
  input  logic       dfi_phyupd_req,
  input  logic [1:0] dfi_phyupd_type,
  output logic       dfi_phyupd_ack,
  input  logic       dfi_phymstr_req,
  output logic       dfi_phymstr_ack,
  output logic       dfi_lp_ctrl_req,
  output logic [5:0] dfi_lp_ctrl_wakeup,
  input  logic       dfi_lp_ctrl_ack,
  output logic [1:0] phyupd_type_lat,
  output logic       phyupd_resp_err,
  output logic [2:0] state
);

  localparam int UW = $clog2(TPHYUPD_RESP + 1);
  localparam int CW = $clog2(TCTRLUPD_MAX + TCTRLUPD_MIN + 1);
  localparam int LW = $clog2(TLP_RESP + 1);
  localparam logic [UW-1:0] UPD_LIMIT = UW'(TPHYUPD_RESP);
  localparam logic [CW-1:0] CTRL_MIN  = CW'(TCTRLUPD_MIN);
  localparam logic [CW-1:0] CTRL_LAST = CW'(TCTRLUPD_MAX - 1);
  localparam logic [LW-1:0] LP_LAST   = LW'(TLP_RESP - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PHYUPD      = 3'd1,
    PHYMSTR     = 3'd2,
    CTRLUPD     = 3'd3,
    CTRLUPD_END = 3'd4,
    LP_REQ      = 3'd5,
    LP_ACTIVE   = 3'd6,
    LP_EXIT     = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic            ctrlupd_req_q, ctrlupd_req_d;
  logic            phyupd_ack_q, phyupd_ack_d;
  logic            phymstr_ack_q, phymstr_ack_d;
  logic            lp_req_q, lp_req_d;
  logic [5:0]      wakeup_q, wakeup_d;
  logic            lp_active_q, lp_active_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic [1:0]      type_lat_q, type_lat_d;
  logic            err_q, err_d;
  logic            ack_seen_q, ack_seen_d;
  logic [CW-1:0]   ctrl_cnt_q, ctrl_cnt_d;
  logic [LW-1:0]   lp_cnt_q, lp_cnt_d;
  logic [UW-1:0]   upd_cnt_q, upd_cnt_d;

  // Arbitration and per-transaction sequencing; init_start aborts everything without pulses.
  always_comb begin
    state_d       = state_q;
    ctrlupd_req_d = ctrlupd_req_q;
    phyupd_ack_d  = phyupd_ack_q;
    phymstr_ack_d = phymstr_ack_q;
    lp_req_d      = lp_req_q;
    wakeup_d      = wakeup_q;
    lp_active_d   = lp_active_q;
    done_d        = 1'b0;
    timeout_d     = 1'b0;
    type_lat_d    = type_lat_q;
    ack_seen_d    = ack_seen_q;
    ctrl_cnt_d    = ctrl_cnt_q;
    lp_cnt_d      = lp_cnt_q;
    if (init_start) begin
      state_d       = IDLE;
      ctrlupd_req_d = 1'b0;
      phyupd_ack_d  = 1'b0;
      phymstr_ack_d = 1'b0;
      lp_req_d      = 1'b0;
      lp_active_d   = 1'b0;
      ack_seen_d    = 1'b0;
      ctrl_cnt_d    = {CW{1'b0}};
      lp_cnt_d      = {LW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (dfi_phyupd_req && mc_idle) begin
            state_d      = PHYUPD;
            phyupd_ack_d = 1'b1;
            type_lat_d   = dfi_phyupd_type;
          end else if (dfi_phymstr_req && mc_idle) begin
            state_d       = PHYMSTR;
            phymstr_ack_d = 1'b1;
          end else if (mc_ctrlupd_req) begin
            state_d       = CTRLUPD;
            ctrlupd_req_d = 1'b1;
            ack_seen_d    = 1'b0;
            ctrl_cnt_d    = {CW{1'b0}};
          end else if (mc_lp_req) begin
            state_d  = LP_REQ;
            lp_req_d = 1'b1;
            wakeup_d = mc_lp_wakeup;
            lp_cnt_d = {LW{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        PHYUPD: begin
          if (!dfi_phyupd_req) begin
            state_d      = IDLE;
            phyupd_ack_d = 1'b0;
          end else begin
            phyupd_ack_d = 1'b1;
          end
        end
        PHYMSTR: begin
          if (!dfi_phymstr_req) begin
            state_d       = IDLE;
            phymstr_ack_d = 1'b0;
          end else begin
            phymstr_ack_d = 1'b1;
          end
        end
        CTRLUPD: begin
          // After the first ack the counter restarts and measures the hold time instead.
          if (ack_seen_q) begin
            if (ctrl_cnt_q >= CTRL_MIN) begin
              state_d       = CTRLUPD_END;
              ctrlupd_req_d = 1'b0;
            end else begin
              ctrl_cnt_d = ctrl_cnt_q + CW'(1);
            end
          end else if (dfi_ctrlupd_ack) begin
            ack_seen_d = 1'b1;
            if (CTRL_MIN == {CW{1'b0}}) begin
              state_d       = CTRLUPD_END;
              ctrlupd_req_d = 1'b0;
            end else begin
              ctrl_cnt_d = CW'(1);
            end
          end else if (ctrl_cnt_q == CTRL_LAST) begin
            state_d       = CTRLUPD_END;
            ctrlupd_req_d = 1'b0;
          end else begin
            ctrl_cnt_d = ctrl_cnt_q + CW'(1);
          end
        end
        CTRLUPD_END: begin
          if (!dfi_ctrlupd_ack) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            ack_seen_d = 1'b0;
          end else begin
            state_d = CTRLUPD_END;
          end
        end
        LP_REQ: begin
          if (dfi_lp_ctrl_ack) begin
            state_d     = LP_ACTIVE;
            lp_active_d = 1'b1;
          end else if (!mc_lp_req) begin
            state_d  = IDLE;
            lp_req_d = 1'b0;
          end else if (lp_cnt_q == LP_LAST) begin
            state_d   = IDLE;
            lp_req_d  = 1'b0;
            timeout_d = 1'b1;
          end else begin
            lp_cnt_d = lp_cnt_q + LW'(1);
          end
        end
        LP_ACTIVE: begin
          if (!mc_lp_req) begin
            state_d  = LP_EXIT;
            lp_req_d = 1'b0;
          end else begin
            lp_req_d = 1'b1;
          end
        end
        LP_EXIT: begin
          if (!dfi_lp_ctrl_ack) begin
            state_d     = IDLE;
            lp_active_d = 1'b0;
          end else begin
            state_d = LP_EXIT;
          end
        end
        default: begin
          state_d       = IDLE;
          ctrlupd_req_d = 1'b0;
          phyupd_ack_d  = 1'b0;
          phymstr_ack_d = 1'b0;
          lp_req_d      = 1'b0;
          lp_active_d   = 1'b0;
        end
      endcase
    end
  end

  // PHY update response watchdog: sticky error once a request waits too long for ack.
  always_comb begin
    upd_cnt_d = upd_cnt_q;
    err_d     = err_q;
    if (init_start || !dfi_phyupd_req || phyupd_ack_q) begin
      upd_cnt_d = {UW{1'b0}};
    end else if (upd_cnt_q != UPD_LIMIT) begin
      upd_cnt_d = upd_cnt_q + UW'(1);
    end else begin
      upd_cnt_d = upd_cnt_q;
    end
    if (upd_cnt_d == UPD_LIMIT) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State, output and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      ctrlupd_req_q <= 1'b0;
      phyupd_ack_q  <= 1'b0;
      phymstr_ack_q <= 1'b0;
      lp_req_q      <= 1'b0;
      wakeup_q      <= 6'd0;
      lp_active_q   <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      type_lat_q    <= 2'd0;
      err_q         <= 1'b0;
      ack_seen_q    <= 1'b0;
      ctrl_cnt_q    <= {CW{1'b0}};
      lp_cnt_q      <= {LW{1'b0}};
      upd_cnt_q     <= {UW{1'b0}};
    end else begin
      state_q       <= state_d;
      ctrlupd_req_q <= ctrlupd_req_d;
      phyupd_ack_q  <= phyupd_ack_d;
      phymstr_ack_q <= phymstr_ack_d;
      lp_req_q      <= lp_req_d;
      wakeup_q      <= wakeup_d;
      lp_active_q   <= lp_active_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      type_lat_q    <= type_lat_d;
      err_q         <= err_d;
      ack_seen_q    <= ack_seen_d;
      ctrl_cnt_q    <= ctrl_cnt_d;
      lp_cnt_q      <= lp_cnt_d;
      upd_cnt_q     <= upd_cnt_d;
    end
  end

  // DFI request/ack pins drop in the same cycle init_start rises.
  assign dfi_ctrlupd_req    = ctrlupd_req_q & ~init_start;
  assign dfi_phyupd_ack     = phyupd_ack_q & ~init_start;
  assign dfi_phymstr_ack    = phymstr_ack_q & ~init_start;
  assign dfi_lp_ctrl_req    = lp_req_q & ~init_start;
  assign dfi_lp_ctrl_wakeup = wakeup_q;
  assign mc_lp_active       = lp_active_q;
  assign mc_lp_timeout      = timeout_q;
  assign mc_ctrlupd_done    = done_q;
  assign phyupd_type_lat    = type_lat_q;
  assign phyupd_resp_err    = err_q;
  assign state              = state_q;

endmodule

// File: tb/tb_dfi_ctrl_arbiter.sv
// Directed self-checking bench for dfi_ctrl_arbiter; outputs are sampled 1ns after each rising edge.
module tb_dfi_ctrl_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       init_start;
  logic       mc_idle;
  logic       mc_ctrlupd_req;
  logic       mc_ctrlupd_done;
  logic       mc_lp_req;
  logic [5:0] mc_lp_wakeup;
  logic       mc_lp_active;
  logic       mc_lp_timeout;
  logic       dfi_ctrlupd_req;
  logic       dfi_ctrlupd_ack;
  logic       dfi_phyupd_req;
  logic [1:0] dfi_phyupd_type;
  logic       dfi_phyupd_ack;
  logic       dfi_phymstr_req;
  logic       dfi_phymstr_ack;
  logic       dfi_lp_ctrl_req;
  logic [5:0] dfi_lp_ctrl_wakeup;
  logic       dfi_lp_ctrl_ack;
  logic [1:0] phyupd_type_lat;
  logic       phyupd_resp_err;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  dfi_ctrl_arbiter dut (
    .clock(clock), .reset(reset), .init_start(init_start), .mc_idle(mc_idle),
    .mc_ctrlupd_req(mc_ctrlupd_req), .mc_ctrlupd_done(mc_ctrlupd_done),
    .mc_lp_req(mc_lp_req), .mc_lp_wakeup(mc_lp_wakeup), .mc_lp_active(mc_lp_active),
    .mc_lp_timeout(mc_lp_timeout), .dfi_ctrlupd_req(dfi_ctrlupd_req),
    .dfi_ctrlupd_ack(dfi_ctrlupd_ack), .dfi_phyupd_req(dfi_phyupd_req),
    .dfi_phyupd_type(dfi_phyupd_type), .dfi_phyupd_ack(dfi_phyupd_ack),
    .dfi_phymstr_req(dfi_phymstr_req), .dfi_phymstr_ack(dfi_phymstr_ack),
    .dfi_lp_ctrl_req(dfi_lp_ctrl_req), .dfi_lp_ctrl_wakeup(dfi_lp_ctrl_wakeup),
    .dfi_lp_ctrl_ack(dfi_lp_ctrl_ack), .phyupd_type_lat(phyupd_type_lat),
    .phyupd_resp_err(phyupd_resp_err), .state(state)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({dfi_ctrlupd_req, dfi_phyupd_ack, dfi_phymstr_ack, dfi_lp_ctrl_req, mc_lp_active,
         mc_lp_timeout, mc_ctrlupd_done, phyupd_resp_err} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000000", {dfi_ctrlupd_req, dfi_phyupd_ack,
               dfi_phymstr_ack, dfi_lp_ctrl_req, mc_lp_active, mc_lp_timeout, mc_ctrlupd_done,
               phyupd_resp_err});
    end
    n_cmp++;
    if ({state, phyupd_type_lat, dfi_lp_ctrl_wakeup} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_state: got state=%0d type=%0d wake=%h want 0", state, phyupd_type_lat,
               dfi_lp_ctrl_wakeup);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_phyupd;
    mc_idle = 1'b1;
    dfi_phyupd_type = 2'd2;
    dfi_phyupd_req = 1'b1;
    tick();
    n_cmp++;
    if ({dfi_phyupd_ack, phyupd_type_lat, state} !== {1'b1, 2'd2, 3'd1}) begin
      n_bad++;
      $display("FAIL phyupd_grant: got ack=%b type=%0d state=%0d want 1/2/1", dfi_phyupd_ack,
               phyupd_type_lat, state);
    end
    dfi_phyupd_type = 2'd1;
    tick();
    n_cmp++;
    if ({dfi_phyupd_ack, phyupd_type_lat} !== {1'b1, 2'd2}) begin
      n_bad++;
      $display("FAIL phyupd_hold: got ack=%b type=%0d want 1/2", dfi_phyupd_ack, phyupd_type_lat);
    end
    dfi_phyupd_req = 1'b0;
    tick();
    n_cmp++;
    if ({dfi_phyupd_ack, state} !== {1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL phyupd_release: got ack=%b state=%0d want 0/0", dfi_phyupd_ack, state);
    end
  endtask

  task automatic test_priority;
    logic [3:0] exp_v [9];
    logic [3:0] obs;
    exp_v = '{4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    mc_idle = 1'b1;
    dfi_phyupd_req = 1'b1;
    dfi_phymstr_req = 1'b1;
    mc_ctrlupd_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      obs = {dfi_ctrlupd_req, dfi_phyupd_ack, dfi_phymstr_ack, mc_ctrlupd_done};
      n_cmp++;
      if (obs !== exp_v[i]) begin
        n_bad++;
        $display("FAIL priority_step%0d: got ctrl/upd/mstr/done=%b want %b", i, obs, exp_v[i]);
      end
      n_cmp++;
      if ($countones({dfi_ctrlupd_req, dfi_phyupd_ack, dfi_phymstr_ack, dfi_lp_ctrl_req}) > 1) begin
        n_bad++;
        $display("FAIL priority_exclusive%0d: got %b want at most one high", i,
                 {dfi_ctrlupd_req, dfi_phyupd_ack, dfi_phymstr_ack, dfi_lp_ctrl_req});
      end
      case (i)
        0: dfi_phyupd_req = 1'b0;
        2: dfi_phymstr_req = 1'b0;
        4: begin
          mc_ctrlupd_req = 1'b0;
          dfi_ctrlupd_ack = 1'b1;
        end
        7: dfi_ctrlupd_ack = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_lp_timeout;
    int hi;
    int pulses;
    hi = 0;
    pulses = 0;
    mc_lp_wakeup = 6'h0A;
    mc_lp_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) mc_lp_wakeup = 6'h15;
      if (dfi_lp_ctrl_req) begin
        hi++;
        n_cmp++;
        if (dfi_lp_ctrl_wakeup !== 6'h0A) begin
          n_bad++;
          $display("FAIL lp_wakeup_stable: got %h want 0a at cycle %0d", dfi_lp_ctrl_wakeup, i);
        end
      end
      if (mc_lp_timeout) begin
        pulses++;
        mc_lp_req = 1'b0;
        n_cmp++;
        if ({i[3:0], dfi_lp_ctrl_req} !== {4'd9, 1'b0}) begin
          n_bad++;
          $display("FAIL lp_timeout_cycle: got cycle=%0d req=%b want 9/0", i, dfi_lp_ctrl_req);
        end
      end
    end
    n_cmp++;
    if (hi !== 8) begin
      n_bad++;
      $display("FAIL lp_req_cycles: got %0d want 8", hi);
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL lp_timeout_pulses: got %0d want 1", pulses);
    end
    mc_lp_req = 1'b0;
    mc_lp_wakeup = 6'h00;
  endtask

  task automatic test_ctrlupd;
    logic exp_req;
    logic exp_done;
    mc_ctrlupd_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_req = (i <= 5) ? 1'b1 : 1'b0;
      exp_done = (i == 8) ? 1'b1 : 1'b0;
      n_cmp++;
      if (dfi_ctrlupd_req !== exp_req) begin
        n_bad++;
        $display("FAIL ctrlupd_req_c%0d: got %b want %b", i, dfi_ctrlupd_req, exp_req);
      end
      n_cmp++;
      if (mc_ctrlupd_done !== exp_done) begin
        n_bad++;
        $display("FAIL ctrlupd_done_c%0d: got %b want %b", i, mc_ctrlupd_done, exp_done);
      end
      if (i == 1) mc_ctrlupd_req = 1'b0;
      if (i == 3) dfi_ctrlupd_ack = 1'b1;
      if (i == 7) dfi_ctrlupd_ack = 1'b0;
    end
  endtask

  task automatic test_lp_exit;
    mc_lp_wakeup = 6'h21;
    mc_lp_req = 1'b1;
    tick();
    n_cmp++;
    if ({dfi_lp_ctrl_req, dfi_lp_ctrl_wakeup, state} !== {1'b1, 6'h21, 3'd5}) begin
      n_bad++;
      $display("FAIL lp_enter: got req=%b wake=%h state=%0d want 1/21/5", dfi_lp_ctrl_req,
               dfi_lp_ctrl_wakeup, state);
    end
    dfi_lp_ctrl_ack = 1'b1;
    tick();
    n_cmp++;
    if ({dfi_lp_ctrl_req, mc_lp_active, state} !== {1'b1, 1'b1, 3'd6}) begin
      n_bad++;
      $display("FAIL lp_active: got req=%b act=%b state=%0d want 1/1/6", dfi_lp_ctrl_req,
               mc_lp_active, state);
    end
    mc_lp_req = 1'b0;
    tick();
    n_cmp++;
    if ({dfi_lp_ctrl_req, mc_lp_active, state} !== {1'b0, 1'b1, 3'd7}) begin
      n_bad++;
      $display("FAIL lp_exit: got req=%b act=%b state=%0d want 0/1/7", dfi_lp_ctrl_req,
               mc_lp_active, state);
    end
    dfi_lp_ctrl_ack = 1'b0;
    tick();
    n_cmp++;
    if ({mc_lp_active, state} !== {1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL lp_exit_done: got act=%b state=%0d want 0/0", mc_lp_active, state);
    end
  endtask

  task automatic test_resp_err;
    logic exp_err;
    mc_idle = 1'b0;
    dfi_phyupd_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_err = (i >= 16) ? 1'b1 : 1'b0;
      n_cmp++;
      if ({dfi_phyupd_ack, phyupd_resp_err} !== {1'b0, exp_err}) begin
        n_bad++;
        $display("FAIL resp_err_c%0d: got ack=%b err=%b want 0/%b", i, dfi_phyupd_ack,
                 phyupd_resp_err, exp_err);
      end
    end
    dfi_phyupd_req = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (phyupd_resp_err !== 1'b1) begin
      n_bad++;
      $display("FAIL resp_err_sticky: got %b want 1", phyupd_resp_err);
    end
  endtask

  task automatic test_lp_init;
    mc_lp_wakeup = 6'h3F;
    mc_lp_req = 1'b1;
    tick();
    dfi_lp_ctrl_ack = 1'b1;
    tick();
    n_cmp++;
    if ({dfi_lp_ctrl_req, mc_lp_active, state} !== {1'b1, 1'b1, 3'd6}) begin
      n_bad++;
      $display("FAIL init_pre: got req=%b act=%b state=%0d want 1/1/6", dfi_lp_ctrl_req,
               mc_lp_active, state);
    end
    init_start = 1'b1;
    #1;
    n_cmp++;
    if ({dfi_lp_ctrl_req, state} !== {1'b0, 3'd6}) begin
      n_bad++;
      $display("FAIL init_same_cycle: got req=%b state=%0d want 0/6", dfi_lp_ctrl_req, state);
    end
    tick();
    n_cmp++;
    if ({state, mc_lp_active, mc_lp_timeout, dfi_lp_ctrl_req} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL init_abort: got state=%0d act=%b to=%b req=%b want 0/0/0/0", state,
               mc_lp_active, mc_lp_timeout, dfi_lp_ctrl_req);
    end
    tick();
    n_cmp++;
    if ({state, mc_lp_timeout} !== {3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL init_blocks: got state=%0d to=%b want 0/0", state, mc_lp_timeout);
    end
    init_start = 1'b0;
    dfi_lp_ctrl_ack = 1'b0;
    mc_lp_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    mc_idle = 1'b1;
    dfi_phymstr_req = 1'b1;
    tick();
    n_cmp++;
    if (dfi_phymstr_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_grant: got %b want 1", dfi_phymstr_ack);
    end
    reset = 1'b1;
    dfi_phymstr_req = 1'b0;
    tick();
    n_cmp++;
    if ({dfi_phymstr_ack, state, phyupd_resp_err} !== {1'b0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_clear: got ack=%b state=%0d err=%b want 0/0/0", dfi_phymstr_ack,
               state, phyupd_resp_err);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    init_start = 1'b0;
    mc_idle = 1'b0;
    mc_ctrlupd_req = 1'b0;
    mc_lp_req = 1'b0;
    mc_lp_wakeup = 6'h00;
    dfi_ctrlupd_ack = 1'b0;
    dfi_phyupd_req = 1'b0;
    dfi_phyupd_type = 2'd0;
    dfi_phymstr_req = 1'b0;
    dfi_lp_ctrl_ack = 1'b0;
    test_reset();
    test_phyupd();
    test_priority();
    test_lp_timeout();
    test_ctrlupd();
    test_lp_exit();
    test_resp_err();
    test_lp_init();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dfi_ctrl_arbiter.md
Name: dfi_ctrl_arbiter

Overview:
- MC-side sequencer for the DFI update, PHY-master and low-power-control handshakes.
- Admits one DFI side-band transaction at a time, so forbidden DFI combinations cannot occur by construction (phyupd_ack & phymstr_ack, ctrlupd_req & phyupd_ack, init_start with any grant or request).
- Enforces tlp_resp and tphyupd_resp timing.
- Sits between the memory-controller command scheduler and the DFI control pins driven by the DFI agent.

Parameters:
TLP_RESP, 8, max cycles dfi_lp_ctrl_req may stay high without dfi_lp_ctrl_ack
TPHYUPD_RESP, 16, max cycles from dfi_phyupd_req rise to dfi_phyupd_ack
TCTRLUPD_MIN, 2, cycles dfi_ctrlupd_req is held after dfi_ctrlupd_ack is first seen
TCTRLUPD_MAX, 32, max cycles dfi_ctrlupd_req is held waiting for ack

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high
init_start  in  1  DFI init in progress; blocks all grants
mc_idle  in  1  MC traffic quiesced; required before phyupd/phymstr ack
mc_ctrlupd_req  in  1  MC requests controller update (level)
mc_ctrlupd_done  out  1  one-cycle pulse, ctrlupd sequence finished
mc_lp_req  in  1  MC requests low-power entry (level, held while LP wanted)
mc_lp_wakeup  in  6  wakeup code, sampled when LP sequence starts
mc_lp_active  out  1  high while PHY acknowledges LP
mc_lp_timeout  out  1  one-cycle pulse, LP request dropped on tlp_resp expiry
dfi_ctrlupd_req  out  1  DFI ctrlupd request
dfi_ctrlupd_ack  in  1  DFI ctrlupd acknowledge
dfi_phyupd_req  in  1  DFI PHY update request
dfi_phyupd_type  in  2  DFI PHY update type
dfi_phyupd_ack  out  1  DFI PHY update acknowledge
dfi_phymstr_req  in  1  DFI PHY master request
dfi_phymstr_ack  out  1  DFI PHY master acknowledge
dfi_lp_ctrl_req  out  1  DFI LP control request
dfi_lp_ctrl_wakeup  out  6  DFI LP wakeup, held stable while req high
dfi_lp_ctrl_ack  in  1  DFI LP acknowledge
phyupd_type_lat  out  2  dfi_phyupd_type captured at grant
phyupd_resp_err  out  1  sticky; phyupd_req unacked for TPHYUPD_RESP cycles; cleared by reset only
state  out  3  FSM state, debug

Behaviour:
- Reset: all outputs 0; FSM to IDLE; all counters 0.
- All outputs are registered.
- dfi_ctrlupd_req, dfi_lp_ctrl_req, dfi_phyupd_ack and dfi_phymstr_ack are additionally ANDed combinationally with ~init_start.
- FSM states:
  - IDLE=0, PHYUPD=1, PHYMSTR=2, CTRLUPD=3, CTRLUPD_END=4, LP_REQ=5, LP_ACTIVE=6, LP_EXIT=7.
- IDLE, with init_start=0, grants the highest pending request in this priority order:
  - dfi_phyupd_req (only if mc_idle) -> PHYUPD;
  - dfi_phymstr_req (only if mc_idle) -> PHYMSTR;
  - mc_ctrlupd_req -> CTRLUPD;
  - mc_lp_req -> LP_REQ.
  - With init_start=1, IDLE stays IDLE.
- Grant latency is 1 cycle: the request is seen at edge N and the DFI output is high from edge N+1.
- PHYUPD:
  - dfi_phyupd_ack=1; phyupd_type_lat captured on entry.
  - When dfi_phyupd_req is sampled 0, ack goes 0 on the next edge and the FSM returns to IDLE.
- PHYMSTR: identical to PHYUPD, using the phymstr signals.
- phyupd response counter:
  - counts cycles with dfi_phyupd_req=1 and dfi_phyupd_ack=0; cleared when ack is high or req is low;
  - on reaching TPHYUPD_RESP, phyupd_resp_err is set.
  - The request stays pending; arbitration is unchanged.
- CTRLUPD:
  - dfi_ctrlupd_req=1.
  - Once ack is seen, hold req for TCTRLUPD_MIN further cycles, then drop it -> CTRLUPD_END.
  - If no ack within TCTRLUPD_MAX cycles, drop req -> CTRLUPD_END.
- CTRLUPD_END: wait for dfi_ctrlupd_ack=0, pulse mc_ctrlupd_done, -> IDLE.
- LP_REQ:
  - dfi_lp_ctrl_req=1; dfi_lp_ctrl_wakeup=mc_lp_wakeup latched on entry.
  - If ack is seen -> LP_ACTIVE with mc_lp_active=1.
  - If req=1 & ack=0 for TLP_RESP consecutive cycles, req goes 0 on the next edge, mc_lp_timeout pulses, -> IDLE.
  - mc_lp_req=0 before ack: drop req -> IDLE.
- LP_ACTIVE: req held high; when mc_lp_req=0, drop req -> LP_EXIT.
- LP_EXIT: wait for ack=0, clear mc_lp_active, -> IDLE.
- mc_lp_req held high after a timeout is re-arbitrated in IDLE as a new request.
- Simultaneous requests in IDLE resolve by the priority order above. Requests arriving while the FSM is busy wait; no preemption.
- init_start rising mid-transaction:
  - gated outputs drop in the same cycle;
  - FSM goes to IDLE on the next edge; counters clear; no done/timeout pulse.
- Reset mid-transaction: outputs return to 0 at the next edge, no pulses.

Test Plan:
1. Reset then dfi_phyupd_req=1, mc_idle=1, type=2 -> dfi_phyupd_ack=1 at the next edge, phyupd_type_lat=2; req drops -> ack=0 exactly 1 cycle later.
2. dfi_phyupd_req, dfi_phymstr_req and mc_ctrlupd_req all rise in the same cycle -> phyupd granted first; after phyupd completes, phymstr ack; then ctrlupd. At no cycle are two acks/reqs high together.
3. mc_lp_req=1, wakeup=6'h0A, PHY never acks -> dfi_lp_ctrl_req high for exactly 8 cycles then 0; one mc_lp_timeout pulse; wakeup=6'h0A throughout.
4. mc_ctrlupd_req=1, PHY acks after 3 cycles and drops ack 1 cycle after req falls -> req high for 3+2 cycles; mc_ctrlupd_done pulse 1 cycle after ack falls.
5. mc_idle=0 with dfi_phyupd_req=1 held for 20 cycles -> no ack; phyupd_resp_err set at cycle 16 and stays set.
6. During LP_ACTIVE, assert init_start -> dfi_lp_ctrl_req=0 in the same cycle; FSM IDLE next edge; no timeout pulse.
